decode_stage: RTL and testbench

//  Instruction-decode stage of the 5-stage MIPS core, directly downstream of fetch.

---
 rtl/decode_stage.sv | 142 ++++++++++++++
 tb/tb_decode_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register file, control decode, beq/j resolution,
// load-use stall with bubble insertion. Optional macro: WB_BYPASS_EN (same-cycle write-back read bypass).
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic [31:0]       pc_plus1,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pcsrc,
  output logic [31:0]       mux1,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [8:0]        ex_ctrl
);

  localparam int unsigned NREG = 1 << REG_AW;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;

  logic [DATA_W-1:0] regs [NREG];
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rs_val, rt_val, imm;
  logic [8:0]        ctrl;
  logic              uses_rt;
  logic              primed;

  assign op    = instruction[31:26];
  assign funct = instruction[5:0];
  assign rs    = instruction[21 +: REG_AW];
  assign rt    = instruction[16 +: REG_AW];
  assign rd    = instruction[11 +: REG_AW];
  assign imm   = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_val = (rs == '0) ? '0 : regs[rs];
    rt_val = (rt == '0) ? '0 : regs[rt];
`ifdef WB_BYPASS_EN
    if (wb_we && wb_addr == rs && rs != '0) rs_val = wb_data;
    if (wb_we && wb_addr == rt && rt != '0) rt_val = wb_data;
`endif
  end

  // ctrl = {reg_dst, alu_src, alu_ctrl[2:0], mem_read, mem_write, reg_write, mem_to_reg}
  always_comb begin
    ctrl = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          6'b100000: ctrl = 9'b1_0_010_0010;
          6'b100010: ctrl = 9'b1_0_110_0010;
          6'b100100: ctrl = 9'b1_0_000_0010;
          6'b100101: ctrl = 9'b1_0_001_0010;
          6'b101010: ctrl = 9'b1_0_111_0010;
          default:   ctrl = '0;
        endcase
      end
      OP_LW:   ctrl = 9'b0_1_010_1011;
      OP_SW:   ctrl = 9'b0_1_010_0100;
      OP_ADDI: ctrl = 9'b0_1_010_0010;
      default: ctrl = '0;
    endcase
  end

  assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  assign stall   = ex_valid && ex_ctrl[3] && (ex_rt != '0) &&
                   ((ex_rt == rs) || (uses_rt && ex_rt == rt));

  always_comb begin
    pcsrc = 1'b0;
    mux1  = pc_plus1;
    if (!stall) begin
      if (op == OP_BEQ && rs_val == rt_val) begin
        pcsrc = 1'b1;
        mux1  = pc_plus1 + imm[31:0];
      end else if (op == OP_J) begin
        pcsrc = 1'b1;
        mux1  = {pc_plus1[31:26], instruction[25:0]};
      end
    end
  end

  // primed stays low for the first edge after reset so fetch's undefined word becomes a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed     <= 1'b0;
      ex_valid   <= 1'b0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
    end else begin
      primed <= 1'b1;
      if (stall || !primed) begin
        ex_valid   <= 1'b0;
        ex_rs_data <= '0;
        ex_rt_data <= '0;
        ex_imm     <= '0;
        ex_rt      <= '0;
        ex_rd      <= '0;
        ex_ctrl    <= '0;
      end else begin
        ex_valid   <= 1'b1;
        ex_rs_data <= rs_val;
        ex_rt_data <= rt_val;
        ex_imm     <= imm;
        ex_rt      <= rt;
        ex_rd      <= rd;
        ex_ctrl    <= ctrl;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against a behavioural pipeline model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, pc_plus1;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pcsrc, stall, ex_valid;
  logic [31:0] mux1, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rt, ex_rd;
  logic [8:0]  ex_ctrl;

  int checks = 0;
  int failures = 0;

  decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pc_plus1(pc_plus1),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pcsrc(pcsrc), .mux1(mux1), .stall(stall), .ex_valid(ex_valid),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  // reference state
  logic [31:0] m_regs [32];
  logic        m_primed, m_valid;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rt, m_rd;
  logic [8:0]  m_ctrl;
  logic        obs_pcsrc, obs_stall, last_stall;
  logic [31:0] obs_mux1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] f);
    return {6'b000000, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  // control word straight from the opcode/funct table
  function automatic logic [8:0] exp_ctrl(input logic [31:0] ins);
    logic reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    logic [2:0] alu;
    {reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg} = '0;
    alu = 3'b000;
    if (ins[31:26] == 6'd0) begin
      reg_dst = 1'b1; reg_write = 1'b1;
      if      (ins[5:0] == 6'h20) alu = 3'b010;
      else if (ins[5:0] == 6'h22) alu = 3'b110;
      else if (ins[5:0] == 6'h24) alu = 3'b000;
      else if (ins[5:0] == 6'h25) alu = 3'b001;
      else if (ins[5:0] == 6'h2a) alu = 3'b111;
      else return 9'd0;
    end else if (ins[31:26] == 6'h23) begin
      alu_src = 1'b1; alu = 3'b010; mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
    end else if (ins[31:26] == 6'h2b) begin
      alu_src = 1'b1; alu = 3'b010; mem_write = 1'b1;
    end else if (ins[31:26] == 6'h08) begin
      alu_src = 1'b1; alu = 3'b010; reg_write = 1'b1;
    end else begin
      return 9'd0;
    end
    return {reg_dst, alu_src, alu, mem_read, mem_write, reg_write, mem_to_reg};
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_primed = 1'b0; m_valid = 1'b0; m_rsd = '0; m_rtd = '0; m_imm = '0;
    m_rt = '0; m_rd = '0; m_ctrl = '0; last_stall = 1'b0;
  endtask

  task automatic check_bundle(input string tag);
    check({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    check({tag, ".rsd"}, ex_rs_data, m_rsd);
    check({tag, ".rtd"}, ex_rt_data, m_rtd);
    check({tag, ".imm"}, ex_imm, m_imm);
    check({tag, ".rt"}, 32'(ex_rt), 32'(m_rt));
    check({tag, ".rd"}, 32'(ex_rd), 32'(m_rd));
    check({tag, ".ctrl"}, 32'(ex_ctrl), 32'(m_ctrl));
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    logic [4:0]  s, t;
    logic [5:0]  o;
    logic [31:0] sv, tv, im, e_mux;
    logic        e_stall, e_pcsrc;
    instruction = ins; pc_plus1 = pc; wb_we = we; wb_addr = wa; wb_data = wd;
    o = ins[31:26]; s = ins[25:21]; t = ins[20:16];
    sv = mread(s, we, wa, wd);
    tv = mread(t, we, wa, wd);
    im = {{16{ins[15]}}, ins[15:0]};
    e_stall = m_valid && m_ctrl[3] && m_rt != 5'd0 &&
              (m_rt == s || ((o == 6'h00 || o == 6'h04 || o == 6'h2b) && m_rt == t));
    e_pcsrc = 1'b0; e_mux = pc;
    if (!e_stall && o == 6'h04 && sv == tv) begin e_pcsrc = 1'b1; e_mux = pc + im; end
    else if (!e_stall && o == 6'h02) begin e_pcsrc = 1'b1; e_mux = {pc[31:26], ins[25:0]}; end
    #1;
    obs_pcsrc = pcsrc; obs_mux1 = mux1; obs_stall = stall;
    check("stall", 32'(stall), 32'(e_stall));
    check("pcsrc", 32'(pcsrc), 32'(e_pcsrc));
    check("mux1", mux1, e_mux);
    @(posedge clk);
    if (e_stall || !m_primed) begin
      m_valid = 1'b0; m_rsd = '0; m_rtd = '0; m_imm = '0; m_rt = '0; m_rd = '0; m_ctrl = '0;
    end else begin
      m_valid = 1'b1; m_rsd = sv; m_rtd = tv; m_imm = im;
      m_rt = t; m_rd = ins[15:11]; m_ctrl = exp_ctrl(ins);
    end
    if (we && wa != 5'd0) m_regs[wa] = wd;
    m_primed = 1'b1;
    last_stall = e_stall;
    #1;
    check_bundle("idex");
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  s, t, d;
    logic [5:0]  f;
    logic [15:0] i;
    s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    i = 16'($urandom);
    case ($urandom_range(0, 8))
      0, 1, 2: begin
        case ($urandom_range(0, 5))
          0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25; 4: f = 6'h2a;
          default: f = 6'($urandom);
        endcase
        return rtype(s, t, d, f);
      end
      3: return itype(6'h23, s, t, i);
      4: return itype(6'h2b, s, t, i);
      5: return itype(6'h08, s, t, i);
      6: return itype(6'h04, s, ($urandom_range(0, 1) == 0) ? s : t, i);
      7: return {6'h02, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ins, pc;
    model_reset();
    rst = 1'b1; instruction = '0; pc_plus1 = 32'h100; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #12;
    check("rst.pcsrc", 32'(pcsrc), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.mux1", mux1, 32'h100);
    check_bundle("rst");
    @(negedge clk);
    rst = 1'b0;

    step(32'd0, 32'd1, 1'b1, 5'd3, 32'd7);
    check("first_bubble", 32'(ex_valid), 32'd0);
    step(32'd0, 32'd2, 1'b1, 5'd4, 32'd7);
    step(32'd0, 32'd3, 1'b1, 5'd6, 32'd3);
    step(itype(6'h04, 5'd3, 5'd4, 16'd4), 32'd10, 1'b0, 5'd0, 32'd0);
    check("beq.pcsrc", 32'(obs_pcsrc), 32'd1);
    check("beq.mux1", obs_mux1, 32'd14);
    step({6'h02, 26'h0000020}, 32'h4000_0005, 1'b0, 5'd0, 32'd0);
    check("j.pcsrc", 32'(obs_pcsrc), 32'd1);
    check("j.mux1", obs_mux1, 32'h4000_0020);
    step(itype(6'h23, 5'd0, 5'd2, 16'd0), 32'd6, 1'b0, 5'd0, 32'd0);
    step(rtype(5'd2, 5'd1, 5'd5, 6'h20), 32'd7, 1'b0, 5'd0, 32'd0);
    check("lu.stall", 32'(obs_stall), 32'd1);
    check("lu.bubble", 32'(ex_valid), 32'd0);
    step(rtype(5'd2, 5'd1, 5'd5, 6'h20), 32'd7, 1'b0, 5'd0, 32'd0);
    check("lu.release", 32'(obs_stall), 32'd0);
    check("lu.issue", 32'(ex_valid), 32'd1);
    step(32'd0, 32'd8, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(rtype(5'd0, 5'd0, 5'd7, 6'h20), 32'd9, 1'b0, 5'd0, 32'd0);
    check("r0.rs", ex_rs_data, 32'd0);
    check("r0.rt", ex_rt_data, 32'd0);
    step(rtype(5'd6, 5'd0, 5'd7, 6'h20), 32'd10, 1'b1, 5'd6, 32'd9);
`ifdef WB_BYPASS_EN
    check("byp.rs", ex_rs_data, 32'd9);
`else
    check("byp.rs", ex_rs_data, 32'd3);
`endif

    pc = 32'd20;
    ins = rand_ins();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        step(32'd0, pc, 1'b1, 5'd5, 32'h55);
        #2 rst = 1'b1;
        #1;
        check("midrst.valid", 32'(ex_valid), 32'd0);
        check("midrst.ctrl", 32'(ex_ctrl), 32'd0);
        model_reset();
        wb_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(32'd0, pc, 1'b0, 5'd0, 32'd0);
        step(rtype(5'd5, 5'd5, 5'd7, 6'h20), pc, 1'b0, 5'd0, 32'd0);
        check("midrst.r5", ex_rs_data, 32'd0);
      end
      step(ins, pc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      if (!last_stall) begin
        pc = obs_pcsrc ? obs_mux1 : pc + 32'd1;
        ins = rand_ins();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
